pkt_order_checker: RTL and testbench
====================================

PKT_ORDER_CHECKER -- requirements
Module: pkt_order_checker

Interface
REQ-001 Parameter DWIDTH, default 16: width of the data word, treated as unsigned.
REQ-002 Parameter MAX_PKT_LEN, default 8: largest legal packet length in beats; AWIDTH = $clog2(MAX_PKT_LEN+1).
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 srst_i  input  1  reset, synchronous and active-high.
REQ-005 snk_data_i  input  DWIDTH  Avalon-ST sink data.
REQ-006 snk_startofpacket_i  input  1  first beat of a packet.
REQ-007 snk_endofpacket_i  input  1  last beat of a packet.
REQ-008 snk_valid_i  input  1  beat present.
REQ-009 snk_ready_o  output  1  checker can accept a beat.
REQ-010 done_o  output  1  one-cycle pulse: the report outputs have been updated.
REQ-011 len_o  output  AWIDTH  accepted length of the last reported packet, saturated at MAX_PKT_LEN.
REQ-012 sorted_o  output  1  last packet was non-decreasing.
REQ-013 err_len_o  output  1  last packet had more than MAX_PKT_LEN beats.
REQ-014 err_frame_o  output  1  framing violation (stray beat or repeated SOP) occurred since the previous report.
REQ-015 pkt_cnt_o  output  16  count of reported packets; wraps from 16'hFFFF to 0.

Function
REQ-016 A beat shall be accepted only in a cycle where snk_valid_i and snk_ready_o are both 1; all other cycles shall leave the internal state unchanged, except for the throttle LFSR.
REQ-017 The FSM shall have three states: IDLE, RECEIVE and REPORT.
REQ-018 IDLE, accepted SOP beat without EOP: len=1, prev=data, sorted=1, go to RECEIVE.
REQ-019 IDLE, accepted SOP beat with EOP: the packet is 1 beat long; go to REPORT with len=1 and sorted=1.
REQ-020 IDLE, accepted beat without SOP: discard the beat, set frame_pend, stay in IDLE.
REQ-021 RECEIVE, accepted beat without SOP:
- len increments and saturates at MAX_PKT_LEN;
- an accepted beat that would make the length exceed MAX_PKT_LEN sets len_err;
- the sorted flag clears if data < prev (unsigned); equal values are legal;
- prev is set to data.
REQ-022 RECEIVE, accepted beat with SOP: set frame_pend, discard the partial packet, and restart the packet with this beat as beat 1 (same handling as REQ-018/019).
REQ-023 An accepted beat with EOP, in RECEIVE or as in REQ-019, shall cause a move to REPORT on the next edge.
- The EOP beat itself is included in the length and the order check before reporting.
REQ-024 REPORT lasts exactly one cycle, then the FSM returns to IDLE.
- During REPORT, snk_ready_o=0 and done_o=1.
- len_o, sorted_o, err_len_o and err_frame_o (= frame_pend) show the packet result.
- pkt_cnt_o increments and frame_pend clears.
REQ-025 Latency: EOP accepted in cycle N means done_o=1 in cycle N+1; the earliest next acceptance is cycle N+2.
REQ-026 The report outputs shall be registered and hold their values until the next REPORT; done_o shall be 0 outside REPORT.
REQ-027 A frame violation occurring in the same accepted beat as EOP (SOP+EOP in RECEIVE) shall appear in that same report.

Reset
REQ-028 While srst_i=1, the block shall drive:
- state = IDLE;
- done_o = 0, len_o = 0, sorted_o = 0, err_len_o = 0, err_frame_o = 0;
- pkt_cnt_o = 0 and frame_pend = 0;
- throttle LFSR = 8'hA5.
REQ-029 snk_ready_o shall be 0 in every cycle where srst_i=1.
REQ-030 A reset applied mid-packet shall discard the partial packet and shall produce no done_o pulse.

Configuration
REQ-031 With macro PKT_ORDER_CHECKER_THROTTLE_EN defined, an 8-bit Fibonacci LFSR shall drive backpressure.
- Polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, advancing every cycle outside reset.
- snk_ready_o = (state != REPORT) && lfsr[0].
REQ-032 Without PKT_ORDER_CHECKER_THROTTLE_EN, the block shall contain no LFSR, and snk_ready_o = (state != REPORT) outside reset.

Verification
REQ-033 Packet 3,5,5,9 (SOP on 3, EOP on 9), valid held high -> one cycle after EOP: done_o=1, len_o=4, sorted_o=1, err_len_o=0, err_frame_o=0, pkt_cnt_o=1.
REQ-034 Packet 7,2,8 -> done_o pulse with len_o=3, sorted_o=0.
REQ-035 Single beat 4 with SOP+EOP -> done_o with len_o=1, sorted_o=1; then a 10-beat ascending packet with MAX_PKT_LEN=8 -> len_o=8, err_len_o=1.
REQ-036 Stray beat 1 in IDLE, then packet 2,3 -> stray beat discarded; report len_o=2, sorted_o=1, err_frame_o=1; the following clean packet reports err_frame_o=0.
REQ-037 Packet 1,2 then SOP beat 9 before EOP, then 9,10 with EOP -> a single report with len_o=3, err_frame_o=1; also srst_i pulsed after 2 beats of a packet -> no done_o, outputs return to 0.
REQ-038 Throttle macro defined, 100 random packets -> no beat accepted while snk_ready_o=0, every report matches the reference model, and pkt_cnt_o=100.

Source files
------------

// File: rtl/pkt_order_checker.sv
// Avalon-ST packet checker: measures packet length, checks non-decreasing order and framing,
// and reports once per packet. Optional backpressure LFSR enabled by PKT_ORDER_CHECKER_THROTTLE_EN.
module pkt_order_checker #(
  parameter  int DWIDTH      = 16,
  parameter  int MAX_PKT_LEN = 8,
  localparam int AWIDTH      = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic              done_o,
  output logic [AWIDTH-1:0] len_o,
  output logic              sorted_o,
  output logic              err_len_o,
  output logic              err_frame_o,
  output logic [15:0]       pkt_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RECEIVE, S_REPORT} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   len_q, len_d;
  logic [DWIDTH-1:0]   prev_q, prev_d;
  logic                sorted_q, sorted_d;
  logic                len_err_q, len_err_d;
  logic                frame_pend_q, frame_pend_d;
  logic [AWIDTH-1:0]   rpt_len_q;
  logic                rpt_sorted_q, rpt_len_err_q, rpt_frame_q;
  logic [15:0]         pkt_cnt_q;
  logic                ready;
  logic                accept;
  logic                rpt_load;

`ifdef PKT_ORDER_CHECKER_THROTTLE_EN
  logic [7:0] lfsr_q;

  // Taps 8,6,5,4 shifted in at bit 0
  always_ff @(posedge clk_i) begin
    if (srst_i) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign ready = !srst_i && (state_q != S_REPORT) && lfsr_q[0];
`else
  assign ready = !srst_i && (state_q != S_REPORT);
`endif

  assign accept = snk_valid_i && ready;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    prev_d       = prev_q;
    sorted_d     = sorted_q;
    len_err_d    = len_err_q;
    frame_pend_d = frame_pend_q;
    case (state_q)
      S_IDLE, S_RECEIVE: begin
        if (accept) begin
          if (snk_startofpacket_i) begin
            // A SOP inside a packet abandons the partial packet and restarts
            if (state_q == S_RECEIVE) frame_pend_d = 1'b1;
            len_d     = AWIDTH'(1);
            prev_d    = snk_data_i;
            sorted_d  = 1'b1;
            len_err_d = 1'b0;
            state_d   = snk_endofpacket_i ? S_REPORT : S_RECEIVE;
          end else if (state_q == S_IDLE) begin
            frame_pend_d = 1'b1;
          end else begin
            if (len_q == AWIDTH'(MAX_PKT_LEN)) len_err_d = 1'b1;
            else                               len_d     = len_q + AWIDTH'(1);
            if (snk_data_i < prev_q) sorted_d = 1'b0;
            prev_d = snk_data_i;
            if (snk_endofpacket_i) state_d = S_REPORT;
          end
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign rpt_load = (state_q != S_REPORT) && (state_d == S_REPORT);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q       <= S_IDLE;
      frame_pend_q  <= 1'b0;
      rpt_len_q     <= '0;
      rpt_sorted_q  <= 1'b0;
      rpt_len_err_q <= 1'b0;
      rpt_frame_q   <= 1'b0;
      pkt_cnt_q     <= 16'd0;
    end else begin
      state_q      <= state_d;
      frame_pend_q <= rpt_load ? 1'b0 : frame_pend_d;
      if (rpt_load) begin
        rpt_len_q     <= len_d;
        rpt_sorted_q  <= sorted_d;
        rpt_len_err_q <= len_err_d;
        rpt_frame_q   <= frame_pend_d;
        pkt_cnt_q     <= pkt_cnt_q + 16'd1;
      end
    end
  end

  // Packet accumulators are always reloaded by an SOP beat before use
  always_ff @(posedge clk_i) begin
    len_q     <= len_d;
    prev_q    <= prev_d;
    sorted_q  <= sorted_d;
    len_err_q <= len_err_d;
  end

  assign snk_ready_o = ready;
  assign done_o      = !srst_i && (state_q == S_REPORT);
  assign len_o       = rpt_len_q;
  assign sorted_o    = rpt_sorted_q;
  assign err_len_o   = rpt_len_err_q;
  assign err_frame_o = rpt_frame_q;
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_order_checker.sv
// Scoreboard bench for pkt_order_checker: directed packets plus randomized traffic,
// checked against a packet-level reference model.
module tb_pkt_order_checker;
  localparam int DW   = 16;
  localparam int MAXL = 8;
  localparam int AW   = $clog2(MAXL + 1);

  logic          clk = 1'b0;
  logic          srst_i;
  logic [DW-1:0] snk_data_i;
  logic          snk_startofpacket_i, snk_endofpacket_i, snk_valid_i;
  logic          snk_ready_o, done_o, sorted_o, err_len_o, err_frame_o;
  logic [AW-1:0] len_o;
  logic [15:0]   pkt_cnt_o;

  pkt_order_checker #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk), .srst_i(srst_i), .snk_data_i(snk_data_i),
    .snk_startofpacket_i(snk_startofpacket_i), .snk_endofpacket_i(snk_endofpacket_i),
    .snk_valid_i(snk_valid_i), .snk_ready_o(snk_ready_o), .done_o(done_o),
    .len_o(len_o), .sorted_o(sorted_o), .err_len_o(err_len_o),
    .err_frame_o(err_frame_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len; bit sorted; bit elen; bit eframe; int cnt; int cyc;
  } rpt_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  rpt_t exp_q[$];
  int   m_beats[$];
  bit   m_in    = 1'b0;
  bit   m_frame = 1'b0;
  int   m_cnt   = 0;
  bit   gap_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet is the list of beats since the last SOP
  function automatic void m_report();
    rpt_t r;
    int n;
    n        = m_beats.size();
    r.len    = (n > MAXL) ? MAXL : n;
    r.elen   = (n > MAXL);
    r.sorted = 1'b1;
    for (int i = 1; i < n; i++) if (m_beats[i] < m_beats[i-1]) r.sorted = 1'b0;
    r.eframe = m_frame;
    m_cnt    = (m_cnt + 1) % 65536;
    r.cnt    = m_cnt;
    r.cyc    = cyc;
    exp_q.push_back(r);
    m_beats.delete();
    m_in    = 1'b0;
    m_frame = 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (srst_i) begin
      m_beats.delete();
      m_in = 1'b0; m_frame = 1'b0; m_cnt = 0;
      exp_q.delete();
    end else if (snk_valid_i && snk_ready_o) begin
      if (snk_startofpacket_i) begin
        if (m_in) m_frame = 1'b1;
        m_beats.delete();
        m_beats.push_back(int'(snk_data_i));
        m_in = 1'b1;
        if (snk_endofpacket_i) m_report();
      end else if (!m_in) begin
        m_frame = 1'b1;
      end else begin
        m_beats.push_back(int'(snk_data_i));
        if (snk_endofpacket_i) m_report();
      end
    end
  end

  always @(negedge clk) begin
    rpt_t r;
    if (srst_i) begin
      chk("ready_in_reset", snk_ready_o, 0);
      chk("done_in_reset", done_o, 0);
    end else if (done_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", done_o, 0);
      end else begin
        r = exp_q.pop_front();
        chk("sb_latency", cyc, r.cyc);
        chk("sb_len", len_o, r.len);
        chk("sb_sorted", sorted_o, r.sorted);
        chk("sb_err_len", err_len_o, r.elen);
        chk("sb_err_frame", err_frame_o, r.eframe);
        chk("sb_pkt_cnt", pkt_cnt_o, r.cnt);
        chk("sb_ready_in_report", snk_ready_o, 0);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      chk("missing_done", done_o, 1);
      void'(exp_q.pop_front());
    end
  end

  task automatic beat(input int d, input bit sop, input bit eop);
    int t;
    if (gap_en && ($urandom % 4 == 0)) begin
      snk_valid_i = 1'b0;
      @(posedge clk); #1;
    end
    snk_data_i          = DW'(d);
    snk_startofpacket_i = sop;
    snk_endofpacket_i   = eop;
    snk_valid_i         = 1'b1;
    t = 0;
    // ready does not depend on the sink inputs, so its negedge value holds at the next edge
    forever begin
      @(negedge clk);
      if (snk_ready_o) break;
      t++;
      if (t > 200) begin
        n_tests++; n_fail++;
        $display("FAIL beat_timeout: snk_ready_o stuck at 0 for %0d cycles, required 1", t);
        $fatal(1, "handshake stalled");
      end
    end
    @(posedge clk); #1;
    snk_valid_i = 1'b0;
  endtask

  task automatic send(input int d[$]);
    for (int i = 0; i < d.size(); i++) beat(d[i], i == 0, i == d.size() - 1);
  endtask

  task automatic chk_rep(input string nm, input int l, input bit s, input bit el,
                         input bit ef, input int c);
    chk({nm, "_done"}, done_o, 1);
    chk({nm, "_len"}, len_o, l);
    chk({nm, "_sorted"}, sorted_o, s);
    chk({nm, "_err_len"}, err_len_o, el);
    chk({nm, "_err_frame"}, err_frame_o, ef);
    chk({nm, "_pkt_cnt"}, pkt_cnt_o, c);
  endtask

  task automatic do_reset();
    srst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    srst_i = 1'b0;
  endtask

  initial begin
    int pk[$];
    int len, rpos, d;
    bit restart;
    srst_i = 1'b1; snk_valid_i = 1'b0; snk_data_i = '0;
    snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done_o, 0);
    chk("rst_ready", snk_ready_o, 0);
    chk("rst_len", len_o, 0);
    chk("rst_sorted", sorted_o, 0);
    chk("rst_err_len", err_len_o, 0);
    chk("rst_err_frame", err_frame_o, 0);
    chk("rst_pkt_cnt", pkt_cnt_o, 0);
    srst_i = 1'b0;

    pk = '{3, 5, 5, 9};  send(pk); chk_rep("p3559", 4, 1, 0, 0, 1);
    pk = '{7, 2, 8};     send(pk); chk_rep("p728", 3, 0, 0, 0, 2);
    pk = '{4};           send(pk); chk_rep("p4", 1, 1, 0, 0, 3);
    pk.delete();
    for (int i = 1; i <= 10; i++) pk.push_back(i);
    send(pk); chk_rep("p10", 8, 1, 1, 0, 4);

    beat(1, 0, 0);
    chk("stray_no_done", done_o, 0);
    pk = '{2, 3};        send(pk); chk_rep("p23", 2, 1, 0, 1, 5);
    pk = '{6, 6};        send(pk); chk_rep("p66", 2, 1, 0, 0, 6);

    beat(1, 1, 0); beat(2, 0, 0); beat(9, 1, 0); beat(9, 0, 0); beat(10, 0, 1);
    chk_rep("restart", 3, 1, 0, 1, 7);
    @(posedge clk); #1;
    chk("hold_done", done_o, 0);
    chk("hold_len", len_o, 3);
    chk("hold_err_frame", err_frame_o, 1);

    beat(5, 1, 0); beat(6, 0, 0);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_done", done_o, 0);
    chk("midrst_len", len_o, 0);
    chk("midrst_err_frame", err_frame_o, 0);
    chk("midrst_pkt_cnt", pkt_cnt_o, 0);

    beat(3, 1, 0); beat(2, 1, 1);
    chk_rep("sop_eop_recv", 1, 1, 0, 1, 1);

    do_reset();
    gap_en = 1'b1;
    for (int p = 0; p < 100; p++) begin
      if ($urandom % 8 == 0) beat($urandom % 16, 0, $urandom % 2);
      len     = 1 + $urandom % 11;
      restart = (len > 2) && ($urandom % 8 == 0);
      rpos    = 1 + $urandom % (len - 1);
      for (int i = 0; i < len; i++) begin
        d = (i == 0 || $urandom % 4 != 0) ? $urandom % 16 : $urandom % 65536;
        beat(d, (i == 0) || (restart && i == rpos), i == len - 1);
      end
    end
    gap_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rand_pkt_cnt", pkt_cnt_o, 100);
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
